// File: rtl/i2c_rx_packetizer.sv
// Drains a quiet I2C slave FIFO message into an uplink packet on a byte stream:
// sync, channel, length, payload, xor checksum.
module i2c_rx_packetizer #(
    parameter int unsigned N         = 12,
    parameter int unsigned QUIET_CYC = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] have_msg_bus,
    input  logic [7:0]   len,
    input  logic [7:0]   s_dout,
    output logic [N-1:0] s_rdreq_bus,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         pkt_done
);

    localparam int unsigned ChW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CntW = $clog2(QUIET_CYC);
    localparam logic [N-1:0] OneN = N'(1);

    typedef enum logic [3:0] {
        StIdle,
        StQuiet,
        StHSync,
        StHCh,
        StHLen,
        StRdReq,
        StRdCap,
        StSendD,
        StSendCs
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [ChW-1:0]  ch_q;
    logic [7:0]      len_prev_q;
    logic [7:0]      rem_q;
    logic [7:0]      csum_q;

    logic [ChW-1:0]  ch_enc;
    logic [7:0]      eff_len;
    logic [7:0]      ch_byte;
    logic [N-1:0]    ch_onehot;

    // Lowest set bit wins.
    always_comb begin
        ch_enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (have_msg_bus[i]) begin
                ch_enc = ChW'(i);
            end
        end
    end

    // A used-word count of 0 with data pending means the 64-deep FIFO is full.
    assign eff_len   = (len[5:0] == 6'd0 && |have_msg_bus) ? 8'd64 : {2'b00, len[5:0]};
    assign ch_byte   = 8'(ch_q);
    assign ch_onehot = OneN << ch_q;
    assign pkt_done  = !rst && (state_q == StSendCs) && tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ch_q        <= '0;
            len_prev_q  <= '0;
            rem_q       <= '0;
            csum_q      <= '0;
            s_rdreq_bus <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            len_prev_q  <= len;
            s_rdreq_bus <= '0;
            unique case (state_q)
                StIdle: begin
                    if (|have_msg_bus) begin
                        ch_q    <= ch_enc;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StQuiet;
                    end
                end
                StQuiet: begin
                    if (have_msg_bus == '0) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (len != len_prev_q || !have_msg_bus[ch_q]) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CntW'(QUIET_CYC - 1)) begin
                        rem_q    <= eff_len;
                        csum_q   <= ch_byte ^ eff_len;
                        tx_data  <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                        state_q  <= StHSync;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHSync: begin
                    if (tx_ready) begin
                        tx_data <= ch_byte;
                        state_q <= StHCh;
                    end
                end
                StHCh: begin
                    if (tx_ready) begin
                        tx_data <= rem_q;
                        state_q <= StHLen;
                    end
                end
                StHLen: begin
                    if (tx_ready) begin
                        tx_valid    <= 1'b0;
                        s_rdreq_bus <= ch_onehot;
                        state_q     <= StRdReq;
                    end
                end
                StRdReq: begin
                    state_q <= StRdCap;
                end
                StRdCap: begin
                    tx_data  <= s_dout;
                    csum_q   <= csum_q ^ s_dout;
                    rem_q    <= rem_q - 8'd1;
                    tx_valid <= 1'b1;
                    state_q  <= StSendD;
                end
                StSendD: begin
                    // Next read only after the current byte has left.
                    if (tx_ready) begin
                        if (rem_q != 8'd0) begin
                            tx_valid    <= 1'b0;
                            s_rdreq_bus <= ch_onehot;
                            state_q     <= StRdReq;
                        end else begin
                            tx_data <= csum_q;
                            state_q <= StSendCs;
                        end
                    end
                end
                StSendCs: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_rx_packetizer.sv
// Bench for i2c_rx_packetizer: slave FIFO model plus expected-packet queue built from
// the framing rules; table of load scenarios and hand-written corner sequences.
module tb_i2c_rx_packetizer;

    localparam int N         = 12;
    localparam int QUIET_CYC = 16;

    logic         clk          = 1'b0;
    logic         rst          = 1'b1;
    logic [N-1:0] have_msg_bus = '0;
    logic [7:0]   len          = '0;
    logic [7:0]   s_dout       = '0;
    logic         tx_ready     = 1'b1;
    logic [N-1:0] s_rdreq_bus;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         busy;
    logic         pkt_done;

    i2c_rx_packetizer #(
        .N         (N),
        .QUIET_CYC (QUIET_CYC),
        .SYNC_BYTE (8'hAA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .have_msg_bus (have_msg_bus),
        .len          (len),
        .s_dout       (s_dout),
        .s_rdreq_bus  (s_rdreq_bus),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .pkt_done     (pkt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        int         n;
        bit         rnd;
        bit         fixed;
        logic [7:0] lb;
        int         total;
    } vec_t;

    vec_t       vt[8];
    logic [7:0] fifo_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         fch = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         rd_cnt, done_cnt, rd_at_done1, first_valid_cyc, quiet_gap, done1_cyc;
    int         last_chg = 0;
    bit         rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave FIFO view: one active channel, 6-bit used-word count.
    task automatic update_inputs();
        logic [N-1:0] hm;
        logic [7:0]   ln;
        hm = '0;
        if (fifo_q.size() != 0) hm[fch] = 1'b1;
        ln = 8'(fifo_q.size() % 64);
        if (hm != have_msg_bus || ln != len) last_chg = cyc;
        have_msg_bus = hm;
        len          = ln;
    endtask

    task automatic tick();
        logic         pv, pr, pd, prst;
        logic [7:0]   pdata;
        logic [N-1:0] prd, oh;
        @(negedge clk);
        pv    = tx_valid;
        pr    = tx_ready;
        pd    = pkt_done;
        prst  = rst;
        pdata = tx_data;
        prd   = s_rdreq_bus;
        @(posedge clk);
        #1;
        if (pd) begin
            done_cnt++;
            if (done_cnt == 1) begin
                done1_cyc   = cyc;
                rd_at_done1 = rd_cnt;
            end
            check("pkt_done_on_xfer", 32'(pv && pr), 1);
        end
        cyc++;
        if (pv && pr) rx_q.push_back(pdata);
        if (pv) check("no_rdreq_while_pending", 32'(prd), 0);
        if (prd != '0) begin
            oh = '0;
            oh[fch] = 1'b1;
            check("rdreq_onehot", 32'(prd), 32'(oh));
            check("rdreq_fifo_nonempty", 32'(fifo_q.size() != 0), 1);
            rd_cnt++;
            if (fifo_q.size() != 0) s_dout = fifo_q.pop_front();
        end
        if (pv && !pr && !prst) begin
            check("stall_valid_held", 32'(tx_valid), 1);
            check("stall_data_held", 32'(tx_data), 32'(pdata));
        end
        if (first_valid_cyc < 0 && tx_valid) begin
            first_valid_cyc = cyc;
            quiet_gap       = cyc - last_chg;
        end
        update_inputs();
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic start();
        rx_q.delete();
        exp_q.delete();
        rd_cnt          = 0;
        done_cnt        = 0;
        rd_at_done1     = -1;
        done1_cyc       = -1;
        first_valid_cyc = -1;
        quiet_gap       = -1;
    endtask

    // Reference framing: sync, channel, length, payload, xor of everything after sync.
    task automatic add_pkt(input int ch, input logic [7:0] pl[$]);
        logic [7:0] cs, l;
        l  = 8'(pl.size());
        cs = 8'(ch) ^ l;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'(ch));
        exp_q.push_back(l);
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            cs ^= pl[i];
        end
        exp_q.push_back(cs);
    endtask

    task automatic load(input int ch, input logic [7:0] pl[$]);
        fch = ch;
        foreach (pl[i]) fifo_q.push_back(pl[i]);
        update_inputs();
    endtask

    task automatic run_to_done(input int exp_done, input int budget);
        int k;
        k = 0;
        while (!(done_cnt >= exp_done && !busy && !tx_valid) && k < budget) begin
            tick();
            k++;
        end
        check("finished_in_budget", 32'(k < budget), 1);
        repeat (2 * QUIET_CYC) tick();
    endtask

    task automatic compare_stream();
        check("stream_length", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("stream_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic check_quiet();
        check("quiet_gap", 32'(quiet_gap >= QUIET_CYC && quiet_gap <= QUIET_CYC + 2), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] extra[$];
        int         k, n;

        start();
        repeat (3) tick();
        check("reset_tx_valid", 32'(tx_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_rdreq", 32'(s_rdreq_bus), 0);
        check("reset_pkt_done", 32'(pkt_done), 0);
        check("reset_tx_data", 32'(tx_data), 0);
        rst = 1'b0;
        tick();

        vt[0] = '{3, 4, 1'b0, 1'b1, 8'h04, 8};
        vt[1] = '{0, 64, 1'b0, 1'b0, 8'h40, 68};
        vt[2] = '{11, 1, 1'b0, 1'b0, 8'h01, 5};
        for (int i = 3; i < 8; i++) begin
            n     = $urandom_range(1, 64);
            vt[i] = '{$urandom_range(0, N - 1), n, 1'b1, 1'b0, 8'(n), n + 4};
        end

        for (int i = 0; i < 8; i++) begin
            start();
            rnd_ready = vt[i].rnd;
            pl.delete();
            if (vt[i].fixed) pl = '{8'h11, 8'h22, 8'h33, 8'h44};
            else for (int j = 0; j < vt[i].n; j++) pl.push_back(8'($urandom));
            add_pkt(vt[i].ch, pl);
            load(vt[i].ch, pl);
            run_to_done(1, 3000);
            if (rx_q.size() > 2) check("len_byte", 32'(rx_q[2]), 32'(vt[i].lb));
            else check("len_byte_present", 32'(rx_q.size()), 3);
            check("total_bytes", 32'(rx_q.size()), 32'(vt[i].total));
            check("read_count", 32'(rd_cnt), 32'(vt[i].n));
            check("done_count", 32'(done_cnt), 1);
            check_quiet();
            if (!vt[i].rnd) check("packet_cycles", 32'(done1_cyc - first_valid_cyc),
                                  32'(3 + 3 * vt[i].n));
            // 03^04^11^22^33^44 = 43
            if (vt[i].fixed && rx_q.size() > 7) check("fixed_csum", 32'(rx_q[7]), 32'h43);
            compare_stream();
        end
        rnd_ready = 1'b0;

        // len ramps 1->2->3 with gaps shorter than the quiet time.
        start();
        pl.delete();
        for (int j = 0; j < 3; j++) pl.push_back(8'($urandom));
        fch = 4;
        for (int j = 0; j < 3; j++) begin
            fifo_q.push_back(pl[j]);
            update_inputs();
            if (j < 2) repeat (10) tick();
        end
        check("ramp_no_early_frame", 32'(first_valid_cyc < 0), 1);
        add_pkt(4, pl);
        run_to_done(1, 1000);
        if (rx_q.size() > 2) check("ramp_len_byte", 32'(rx_q[2]), 3);
        check_quiet();
        compare_stream();

        // Bytes arriving after the length is latched form a second packet.
        start();
        pl.delete();
        extra.delete();
        for (int j = 0; j < 5; j++) pl.push_back(8'($urandom));
        for (int j = 0; j < 2; j++) extra.push_back(8'($urandom));
        load(7, pl);
        k = 0;
        while (first_valid_cyc < 0 && k < 200) begin
            tick();
            k++;
        end
        check("grow_header_seen", 32'(k < 200), 1);
        foreach (extra[j]) fifo_q.push_back(extra[j]);
        update_inputs();
        add_pkt(7, pl);
        add_pkt(7, extra);
        run_to_done(2, 2000);
        check("grow_reads_first", 32'(rd_at_done1), 5);
        check("grow_reads_total", 32'(rd_cnt), 7);
        check("grow_done_count", 32'(done_cnt), 2);
        compare_stream();

        // Reset while the second payload byte is transferring.
        start();
        pl.delete();
        for (int j = 0; j < 5; j++) pl.push_back(8'($urandom));
        load(5, pl);
        k = 0;
        while (!(rx_q.size() == 4 && tx_valid) && k < 300) begin
            tick();
            k++;
        end
        check("abort_point_reached", 32'(k < 300), 1);
        rst = 1'b1;
        tick();
        check("abort_tx_valid", 32'(tx_valid), 0);
        check("abort_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_reads_so_far", 32'(rd_cnt), 2);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h05);
        exp_q.push_back(pl[0]);
        exp_q.push_back(pl[1]);
        extra.delete();
        for (int j = 2; j < 5; j++) extra.push_back(pl[j]);
        add_pkt(5, extra);
        run_to_done(1, 1000);
        check("abort_reads_total", 32'(rd_cnt), 5);
        check("abort_done_count", 32'(done_cnt), 1);
        compare_stream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
